// File: rtl/cbd_sampler.sv
// cbd_sampler: Kyber centered-binomial sampler (SamplePolyCBD_eta).
// Captures one PRF byte string on start and streams 256 coefficients mod Q
// over a valid/ready handshake, freeing the PRF source while sampling runs.
// Optional feature macro: CBD_SIGNED_OUT_EN adds coef_s, the signed a-b.
module cbd_sampler #(
    parameter int unsigned Q      = 3329,
    parameter int unsigned N_COEF = 256,
    parameter int unsigned BUS_W  = 1536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       eta_sel,
    input  logic [BUS_W-1:0] prf_bits,
    output logic             busy,
    output logic             coef_valid,
    input  logic             coef_ready,
    output logic [11:0]      coef,
    output logic [7:0]       coef_idx,
    output logic             done
`ifdef CBD_SIGNED_OUT_EN
    ,
    output logic [2:0]       coef_s
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state;
    // Capture is stored in beta order (cap[k] = beta[k]) and shifted down by
    // 2*eta per transfer, so the next coefficient always sits at a fixed offset.
    logic [BUS_W-1:0] cap;
    logic             eta3;
    logic [BUS_W-1:0] beta_in;
    logic [5:0]       win_next;
    logic [3:0]       ab_start;
    logic [3:0]       ab_next;
    logic             accept;
    logic             xfer;
    logic             last;

    // Returns {a, b}; for eta=2 only the low four window bits contribute.
    function automatic logic [3:0] cbd_ab(input logic [5:0] w, input logic e3);
        logic [1:0] a;
        logic [1:0] b;
        a = 2'(w[0]) + 2'(w[1]) + 2'(w[2] & e3);
        b = e3 ? (2'(w[3]) + 2'(w[4]) + 2'(w[5])) : (2'(w[2]) + 2'(w[3]));
        return {a, b};
    endfunction

    function automatic logic [11:0] cbd_coef(input logic [3:0] ab);
        logic [11:0] c;
        if (ab[3:2] >= ab[1:0]) c = {10'd0, ab[3:2] - ab[1:0]};
        else                    c = 12'(Q) - {10'd0, ab[1:0] - ab[3:2]};
        return c;
    endfunction

`ifdef CBD_SIGNED_OUT_EN
    function automatic logic [2:0] cbd_signed(input logic [3:0] ab);
        return {1'b0, ab[3:2]} - {1'b0, ab[1:0]};
    endfunction
`endif

    // Undo the per-byte bit ordering of the PRF bus: beta[k] = prf_bits[8*(k/8)+7-(k%8)].
    always_comb begin
        beta_in = '0;
        for (int unsigned j = 0; j < BUS_W / 8; j++) begin
            for (int unsigned b = 0; b < 8; b++) begin
                beta_in[8*j + b] = prf_bits[8*j + 7 - b];
            end
        end
    end

    // Handshake qualifiers and the bit windows for the first and the next coefficient.
    always_comb begin
        accept   = start && (state == ST_IDLE) && ((eta_sel == 2'd1) || (eta_sel == 2'd2));
        xfer     = coef_valid && coef_ready;
        last     = (coef_idx == 8'(N_COEF - 1));
        win_next = eta3 ? cap[11:6] : cap[9:4];
        ab_start = cbd_ab(beta_in[5:0], eta_sel == 2'd1);
        ab_next  = cbd_ab(win_next, eta3);
    end

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            coef_valid <= 1'b0;
            coef       <= '0;
            coef_idx   <= '0;
            done       <= 1'b0;
            cap        <= '0;
            eta3       <= 1'b0;
`ifdef CBD_SIGNED_OUT_EN
            coef_s     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cap        <= beta_in;
                        eta3       <= (eta_sel == 2'd1);
                        coef       <= cbd_coef(ab_start);
`ifdef CBD_SIGNED_OUT_EN
                        coef_s     <= cbd_signed(ab_start);
`endif
                        coef_idx   <= '0;
                        coef_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (last) begin
                            coef_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            cap      <= eta3 ? (cap >> 6) : (cap >> 4);
                            coef     <= cbd_coef(ab_next);
`ifdef CBD_SIGNED_OUT_EN
                            coef_s   <= cbd_signed(ab_next);
`endif
                            coef_idx <= coef_idx + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbd_sampler.sv
// Testbench for cbd_sampler: directed vectors plus randomized streams checked
// against a behavioural CBD model computed straight from the beta-bit formula.
module tb_cbd_sampler;

    localparam int Q     = 3329;
    localparam int N     = 256;
    localparam int BUS_W = 1536;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       eta_sel = 2'd0;
    logic [BUS_W-1:0] prf_bits = '0;
    logic             coef_ready = 1'b0;
    logic             busy;
    logic             coef_valid;
    logic [11:0]      coef;
    logic [7:0]       coef_idx;
    logic             done;
`ifdef CBD_SIGNED_OUT_EN
    logic [2:0]       coef_s;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    cbd_sampler #(.Q(Q), .N_COEF(N), .BUS_W(BUS_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .eta_sel    (eta_sel),
        .prf_bits   (prf_bits),
        .busy       (busy),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef       (coef),
        .coef_idx   (coef_idx),
        .done       (done)
`ifdef CBD_SIGNED_OUT_EN
        ,
        .coef_s     (coef_s)
`endif
    );

    // ---------------- reference model ----------------
    function automatic int beta(input logic [BUS_W-1:0] p, input int k);
        return p[8*(k/8) + 7 - (k%8)] ? 1 : 0;
    endfunction

    function automatic int ref_diff(input logic [BUS_W-1:0] p, input int eta, input int i);
        int a = 0;
        int b = 0;
        for (int j = 0; j < eta; j++) begin
            a += beta(p, 2*i*eta + j);
            b += beta(p, 2*i*eta + eta + j);
        end
        return a - b;
    endfunction

    function automatic int ref_coef(input logic [BUS_W-1:0] p, input int eta, input int i);
        int d;
        d = ref_diff(p, eta, i);
        return (d >= 0) ? d : Q + d;
    endfunction

    // Places byte value v as byte j in SHAKE output format (byte MSB at lowest index).
    function automatic logic [BUS_W-1:0] with_byte(input logic [BUS_W-1:0] p, input int j,
                                                   input logic [7:0] v);
        logic [BUS_W-1:0] r;
        r = p;
        for (int b = 0; b < 8; b++) r[8*j + 7 - b] = v[b];
        return r;
    endfunction

    function automatic logic [BUS_W-1:0] rand_prf();
        logic [BUS_W-1:0] r;
        for (int w = 0; w < BUS_W/32; w++) r[32*w +: 32] = $urandom();
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [BUS_W-1:0] p, input logic [1:0] sel);
        prf_bits = p;
        eta_sel  = sel;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Drains the stream with ready high; ends in the cycle after done.
    task automatic wait_done(output bit seen);
        seen = 1'b0;
        coef_ready = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passes++;
        checks++; if (coef_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", coef_valid); else passes++;
        checks++; if (coef !== 12'd0) $display("FAIL reset_coef got %0d want 0", coef); else passes++;
        checks++; if (coef_idx !== 8'd0) $display("FAIL reset_idx got %0d want 0", coef_idx); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passes++;
`ifdef CBD_SIGNED_OUT_EN
        checks++; if (coef_s !== 3'd0) $display("FAIL reset_coef_s got %0d want 0", coef_s); else passes++;
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_stream();
        int exp_idx = 0;
        int done_at = -1;
        coef_ready = 1'b1;
        pulse_start('0, 2'd2);
        for (int n = 1; n <= 400 && done_at < 0; n++) begin
            if (done) begin
                done_at = n;
                checks++;
                if (coef_valid !== 1'b0 || busy !== 1'b1)
                    $display("FAIL zero_done_cycle valid=%0b busy=%0b want 0/1", coef_valid, busy);
                else passes++;
            end else begin
                checks++;
                if (coef_valid !== 1'b1 || coef !== 12'd0 || coef_idx !== 8'(exp_idx) || busy !== 1'b1)
                    $display("FAIL zero_stream valid=%0b coef=%0d idx=%0d busy=%0b want 1/0/%0d/1",
                             coef_valid, coef, coef_idx, busy, exp_idx);
                else passes++;
                exp_idx++;
            end
            tick();
        end
        checks++;
        if (done_at !== 257 || exp_idx !== 256)
            $display("FAIL zero_latency done_at=%0d transfers=%0d want 257/256", done_at, exp_idx);
        else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL zero_busy_after got %0b want 0", busy); else passes++;
    endtask

    task automatic test_directed();
        logic [1:0]       sel  [8] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
        bit               ones [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
        int               bj   [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        logic [7:0]       bv   [8] = '{8'h03, 8'h03, 8'h0C, 8'hC0, 8'h00, 8'h00, 8'h38, 8'h07};
        int               tgt  [8] = '{0, 1, 0, 3, 0, 255, 0, 0};
        int               expc [8] = '{2, 0, 3327, 3327, 0, 0, 3326, 3};
        int               exps [8] = '{2, 0, -2, -2, 0, 0, -3, 3};
        logic [BUS_W-1:0] p;
        bit               found;
        bit               seen;
        for (int t = 0; t < 8; t++) begin
            p = ones[t] ? '1 : with_byte('0, bj[t], bv[t]);
            coef_ready = 1'b1;
            pulse_start(p, sel[t]);
            found = 1'b0;
            for (int n = 0; n < 300; n++) begin
                if (coef_valid && coef_idx == 8'(tgt[t])) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            checks++;
            if (!found || coef !== 12'(expc[t]))
                $display("FAIL directed_%0d idx=%0d found=%0b coef=%0d want %0d", t, tgt[t], found, coef, expc[t]);
            else passes++;
`ifdef CBD_SIGNED_OUT_EN
            checks++;
            if (!found || coef_s !== 3'(exps[t]))
                $display("FAIL directed_s_%0d coef_s=%0d want %0d", t, $signed(coef_s), exps[t]);
            else passes++;
`else
            if (exps[t] > 3) $display("directed vector %0d out of range", t);
`endif
            wait_done(seen);
            checks++; if (!seen) $display("FAIL directed_done_%0d timeout got 0 want 1", t); else passes++;
        end
    endtask

    task automatic test_invalid_eta();
        logic [1:0] bad [2] = '{2'd0, 2'd3};
        for (int t = 0; t < 2; t++) begin
            pulse_start(rand_prf(), bad[t]);
            tick();
            checks++;
            if (busy !== 1'b0 || coef_valid !== 1'b0)
                $display("FAIL invalid_eta_%0d busy=%0b valid=%0b want 0/0", bad[t], busy, coef_valid);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic [BUS_W-1:0] p;
        bit               found = 1'b0;
        bit               seen;
        p = rand_prf();
        coef_ready = 1'b1;
        pulse_start(p, 2'd2);
        for (int n = 0; n < 50; n++) begin
            if (coef_valid && coef_idx == 8'd10) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        coef_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (s == 2) begin
                prf_bits = rand_prf();
                eta_sel  = 2'd1;
                start    = 1'b1;
            end
            tick();
            start = 1'b0;
            checks++;
            if (!found || coef_valid !== 1'b1 || coef_idx !== 8'd10 || coef !== 12'(ref_coef(p, 2, 10)))
                $display("FAIL stall_%0d valid=%0b idx=%0d coef=%0d want 1/10/%0d",
                         s, coef_valid, coef_idx, coef, ref_coef(p, 2, 10));
            else passes++;
        end
        coef_ready = 1'b1;
        tick();
        checks++;
        if (coef_idx !== 8'd11 || coef !== 12'(ref_coef(p, 2, 11)))
            $display("FAIL resume idx=%0d coef=%0d want 11/%0d", coef_idx, coef, ref_coef(p, 2, 11));
        else passes++;
        wait_done(seen);
        checks++; if (!seen) $display("FAIL backpressure_done timeout got 0 want 1"); else passes++;
    endtask

    task automatic test_random_streams();
        logic [BUS_W-1:0] p;
        logic [1:0]       sel;
        int               eta;
        int               exp_idx;
        int               done_at;
        int               errs;
        for (int s = 0; s < 4; s++) begin
            p   = rand_prf();
            sel = 2'($urandom_range(1, 2));
            eta = (sel == 2'd1) ? 3 : 2;
            coef_ready = 1'b1;
            pulse_start(p, sel);
            exp_idx = 0;
            done_at = -1;
            errs    = 0;
            for (int n = 1; n <= 3000 && done_at < 0; n++) begin
                if (done) begin
                    done_at = n;
                end else begin
                    checks++;
                    if (coef_valid !== 1'b1 || coef_idx !== 8'(exp_idx) ||
                        coef !== 12'(ref_coef(p, eta, exp_idx))) begin
                        if (errs < 5)
                            $display("FAIL rand_%0d valid=%0b idx=%0d coef=%0d want 1/%0d/%0d", s,
                                     coef_valid, coef_idx, coef, exp_idx, ref_coef(p, eta, exp_idx));
                        errs++;
                    end else passes++;
`ifdef CBD_SIGNED_OUT_EN
                    checks++;
                    if (coef_s !== 3'(ref_diff(p, eta, exp_idx)))
                        $display("FAIL rand_s_%0d idx=%0d coef_s=%0d want %0d", s, exp_idx,
                                 $signed(coef_s), ref_diff(p, eta, exp_idx));
                    else passes++;
`endif
                end
                coef_ready = ($urandom_range(0, 3) != 0);
                if (coef_valid && coef_ready) exp_idx++;
                // Inputs that must not disturb an active stream.
                prf_bits = rand_prf();
                eta_sel  = 2'($urandom_range(0, 3));
                start    = (done_at < 0) && ($urandom_range(0, 15) == 0);
                tick();
            end
            start = 1'b0;
            checks++;
            if (done_at < 0 || exp_idx !== 256)
                $display("FAIL rand_done_%0d done_at=%0d transfers=%0d want done/256", s, done_at, exp_idx);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        logic [BUS_W-1:0] p;
        bit               found = 1'b0;
        bit               done_seen = 1'b0;
        p = rand_prf();
        coef_ready = 1'b1;
        pulse_start(p, 2'd1);
        for (int n = 0; n < 200; n++) begin
            if (coef_valid && coef_idx == 8'd100) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!found || busy !== 1'b0 || coef_valid !== 1'b0 || coef !== 12'd0 || coef_idx !== 8'd0 || done !== 1'b0)
            $display("FAIL mid_reset found=%0b busy=%0b valid=%0b coef=%0d idx=%0d done=%0b want 1/0/0/0/0/0",
                     found, busy, coef_valid, coef, coef_idx, done);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (done || coef_valid) done_seen = 1'b1;
        end
        checks++; if (done_seen) $display("FAIL mid_reset_quiet got activity want none"); else passes++;
        p = rand_prf();
        pulse_start(p, 2'd2);
        checks++;
        if (coef_valid !== 1'b1 || coef_idx !== 8'd0 || coef !== 12'(ref_coef(p, 2, 0)))
            $display("FAIL mid_reset_restart valid=%0b idx=%0d coef=%0d want 1/0/%0d",
                     coef_valid, coef_idx, coef, ref_coef(p, 2, 0));
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [BUS_W-1:0] p;
        bit               seen;
        wait_done(seen);
        checks++; if (!seen) $display("FAIL b2b_first_done timeout got 0 want 1"); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy got %0b want 0", busy); else passes++;
        p = rand_prf();
        pulse_start(p, 2'd1);
        checks++;
        if (coef_valid !== 1'b1 || coef_idx !== 8'd0 || busy !== 1'b1 || coef !== 12'(ref_coef(p, 3, 0)))
            $display("FAIL b2b_accept valid=%0b idx=%0d busy=%0b coef=%0d want 1/0/1/%0d",
                     coef_valid, coef_idx, busy, coef, ref_coef(p, 3, 0));
        else passes++;
        wait_done(seen);
        checks++; if (!seen) $display("FAIL b2b_second_done timeout got 0 want 1"); else passes++;
    endtask

    initial begin
        test_reset();
        test_zero_stream();
        test_directed();
        test_invalid_eta();
        test_backpressure();
        test_random_streams();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
